// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer for the execute stage.
// Accepts a MUL and stalls the pipeline. It then runs an XLEN-step radix-2 shift-add
// unsigned multiply. When the multiply ends it pulses a one-cycle register-file write
// of the low product word and latches the high word in hi_out.
module mul_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ir,
    input  logic               ir_valid,
    input  logic               flush,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    output logic               stall,
    output logic               busy,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    hi_out
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]      mcand_q, mcand_d;
    logic [XLEN-1:0]      mplr_q, mplr_d;
    logic [RADDR_W-1:0]   rd_q, rd_d;
    logic [RADDR_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;
    logic [XLEN-1:0]      hi_q, hi_d;

    logic                 is_mul;
    logic                 accept;
    logic                 last_step;
    logic [XLEN:0]        sum;
    logic [2*XLEN-1:0]    acc_shift;
    logic                 unused_ir_bits;

    assign is_mul    = ir_valid & (ir[31:29] == 3'd0) & (ir[28:27] == 2'd3);
    assign accept    = (state_q == S_IDLE) & is_mul & ~flush;
    assign last_step = (count_q == CW'(XLEN - 1));

    // The bits below rd are not needed by this block.
    assign unused_ir_bits = ^ir[26-RADDR_W:0];

    // One shift-add step. The upper half plus the partial product is XLEN+1 bits wide,
    // so the carry is shifted down into the accumulator and never lost.
    assign sum       = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
    assign acc_shift = {sum, acc_q[XLEN-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> BUSY -> DONE -> IDLE. A flush in BUSY abandons the operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY: begin
                if (flush)          state_d = S_IDLE;
                else if (last_step) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: stall covers the accept cycle and every BUSY cycle. It is released in DONE
    // so the pipeline advances in the same cycle as the write-back.
    always_comb begin
        stall = ~rst & (accept | (state_q == S_BUSY));
        busy  = (state_q != S_IDLE);
        wb_en = (state_q == S_DONE);
    end

    // Datapath next values: latch operands at accept, then step once per BUSY cycle.
    // The result registers load on the final step, so they are already valid during DONE.
    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        hi_d      = hi_q;
        if (accept) begin
            mcand_d = op_a;
            mplr_d  = op_b;
            rd_d    = ir[26 -: RADDR_W];
            acc_d   = '0;
            count_d = '0;
        end else if ((state_q == S_BUSY) && !flush) begin
            acc_d   = acc_shift;
            mplr_d  = mplr_q >> 1;
            count_d = count_q + 1'b1;
            if (last_step) begin
                wb_data_d = acc_shift[XLEN-1:0];
                hi_d      = acc_shift[2*XLEN-1:XLEN];
                wb_rd_d   = rd_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            hi_q      <= '0;
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            hi_q      <= hi_d;
        end
    end

    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign hi_out  = hi_q;

endmodule
